// File: rtl/trap_ctrl_if.sv
// -----------------------------------------------------------------------------
// trap_ctrl_if
//
// Bundles the interrupt, CSR, pipeline and fetch-redirect signals of the trap
// sequencer. The clock and reset stay plain ports on the module.
//
// Modports:
//   slave  - used by trap_ctrl: takes interrupt levels, CSR values and
//            pipeline status; drives the pipeline controls, the CSR
//            trap-write port, mip_o, busy_o and trap_count_o.
//   master - used by the surrounding core (or a testbench): the mirror image.
//
// Signals (direction as seen by trap_ctrl):
//   intr_ext_i      in   machine external interrupt, level, asynchronous
//   intr_sw_i       in   machine software interrupt, level
//   intr_tmr_i      in   machine timer interrupt, level
//   mstatus_mie_i   in   mstatus.MIE
//   mie_i           in   mie CSR (bits 11/3/7 used)
//   mtvec_i         in   mtvec CSR
//   mepc_i          in   mepc CSR
//   is_mret_i       in   mret in execute stage
//   pipe_ready_i    in   pipeline may be interrupted
//   pc_resume_i     in   PC of oldest uncommitted instruction
//   stall_o         out  freeze fetch/decode
//   flush_o         out  kill in-flight instructions
//   redirect_o      out  load redirect_pc_o into PC
//   redirect_pc_o   out  fetch target
//   trap_we_o       out  CSR trap write strobe
//   mepc_wdata_o    out  value for mepc
//   mcause_wdata_o  out  value for mcause
//   mstatus_trap_o  out  MPIE=MIE, MIE=0
//   mstatus_mret_o  out  MIE=MPIE, MPIE=1
//   mip_o           out  live mip view
//   busy_o          out  sequencer not idle
//   trap_count_o    out  saturating count of traps taken
// -----------------------------------------------------------------------------
interface trap_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             intr_ext_i;
    logic             intr_sw_i;
    logic             intr_tmr_i;
    logic             mstatus_mie_i;
    logic [31:0]      mie_i;
    logic [31:0]      mtvec_i;
    logic [31:0]      mepc_i;
    logic             is_mret_i;
    logic             pipe_ready_i;
    logic [31:0]      pc_resume_i;

    logic             stall_o;
    logic             flush_o;
    logic             redirect_o;
    logic [31:0]      redirect_pc_o;
    logic             trap_we_o;
    logic [31:0]      mepc_wdata_o;
    logic [31:0]      mcause_wdata_o;
    logic             mstatus_trap_o;
    logic             mstatus_mret_o;
    logic [31:0]      mip_o;
    logic             busy_o;
    logic [CNT_W-1:0] trap_count_o;

    modport slave (
        input  intr_ext_i, intr_sw_i, intr_tmr_i, mstatus_mie_i, mie_i,
               mtvec_i, mepc_i, is_mret_i, pipe_ready_i, pc_resume_i,
        output stall_o, flush_o, redirect_o, redirect_pc_o, trap_we_o,
               mepc_wdata_o, mcause_wdata_o, mstatus_trap_o, mstatus_mret_o,
               mip_o, busy_o, trap_count_o
    );

    modport master (
        output intr_ext_i, intr_sw_i, intr_tmr_i, mstatus_mie_i, mie_i,
               mtvec_i, mepc_i, is_mret_i, pipe_ready_i, pc_resume_i,
        input  stall_o, flush_o, redirect_o, redirect_pc_o, trap_we_o,
               mepc_wdata_o, mcause_wdata_o, mstatus_trap_o, mstatus_mret_o,
               mip_o, busy_o, trap_count_o
    );
endinterface

// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl
//
// Trap sequencer for the 3-stage RISC-V core. Arbitrates the machine
// interrupts (MEI > MSI > MTI), drains the pipeline, writes mepc/mcause/
// mstatus through the CSR trap-write port, then flushes and redirects fetch
// to the trap vector. On mret it restores mstatus and redirects to mepc.
//
// Ports:
//   clk  - clock
//   rst  - reset, asynchronous, active-high
//   bus  - trap_ctrl_if.slave (interrupts, CSR values, pipeline controls,
//          CSR trap-write port, status outputs)
//
// Parameters:
//   INTR_SYNC - synchronizer flops on intr_ext_i (0..3, 0 = used directly)
//   CNT_W     - width of the saturating trap counter
//
// Build option:
//   TRAP_VECTORED_EN - when defined, mtvec mode 01 selects vectored entry
//                      (base + 4*code). Otherwise mtvec[1:0] is ignored and
//                      every trap enters at the base address.
//
// Sequence: IDLE -> (DRAIN)* -> SAVE -> REDIR -> IDLE, or IDLE -> MRET -> IDLE.
// -----------------------------------------------------------------------------
module trap_ctrl #(
    parameter int INTR_SYNC = 2,
    parameter int CNT_W     = 16
) (
    input  logic      clk,
    input  logic      rst,
    trap_ctrl_if.slave bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DRAIN = 3'd1;
    localparam logic [2:0] S_SAVE  = 3'd2;
    localparam logic [2:0] S_REDIR = 3'd3;
    localparam logic [2:0] S_MRET  = 3'd4;

    localparam logic [4:0] CODE_MEI = 5'd11;
    localparam logic [4:0] CODE_MSI = 5'd3;
    localparam logic [4:0] CODE_MTI = 5'd7;

    // -------------------------------------------------------------------------
    // External interrupt synchronizer
    // -------------------------------------------------------------------------
    logic ext_sync;

    generate
        if (INTR_SYNC == 0) begin : g_nosync
            assign ext_sync = bus.intr_ext_i;
        end else begin : g_sync
            logic [INTR_SYNC-1:0] sync_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= bus.intr_ext_i;
                    for (int i = 1; i < INTR_SYNC; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign ext_sync = sync_q[INTR_SYNC-1];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Pending / enable evaluation and fixed-priority cause selection
    // -------------------------------------------------------------------------
    logic [31:0] mip_live;
    logic        pend_ext;
    logic        pend_sw;
    logic        pend_tmr;
    logic        take;
    logic [4:0]  code_sel;

    always_comb begin
        mip_live     = 32'd0;
        mip_live[11] = ext_sync;
        mip_live[7]  = bus.intr_tmr_i;
        mip_live[3]  = bus.intr_sw_i;
    end

    assign pend_ext = mip_live[11] & bus.mie_i[11];
    assign pend_sw  = mip_live[3]  & bus.mie_i[3];
    assign pend_tmr = mip_live[7]  & bus.mie_i[7];
    assign take     = bus.mstatus_mie_i & (pend_ext | pend_sw | pend_tmr);

    always_comb begin
        code_sel = CODE_MTI;
        if (pend_ext) begin
            code_sel = CODE_MEI;
        end else if (pend_sw) begin
            code_sel = CODE_MSI;
        end
    end

    // -------------------------------------------------------------------------
    // State and captured trap context
    // -------------------------------------------------------------------------
    logic [2:0]       state_q,    state_d;
    logic [4:0]       cause_q,    cause_d;
    logic [31:0]      epc_q,      epc_d;
    logic [31:0]      mcause_q,   mcause_d;
    logic [31:0]      redir_pc_q, redir_pc_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;

    // Trap entry address, evaluated from the latched cause.
    logic [31:0] tvec_base;
    logic [31:0] trap_target;

    assign tvec_base = {bus.mtvec_i[31:2], 2'b00};

`ifdef TRAP_VECTORED_EN
    // Only mode 01 vectors; modes 00 and 1x enter at the base address.
    assign trap_target = (bus.mtvec_i[1:0] == 2'b01)
                       ? tvec_base + {25'd0, cause_q, 2'b00}
                       : tvec_base;
`else
    assign trap_target = tvec_base;
`endif

    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        epc_d      = epc_q;
        mcause_d   = mcause_q;
        redir_pc_d = redir_pc_q;
        cnt_d      = cnt_q;

        case (state_q)
            S_IDLE: begin
                // mret wins over a simultaneous interrupt; the interrupt is
                // simply re-evaluated once mret has restored mstatus.
                if (bus.is_mret_i) begin
                    state_d    = S_MRET;
                    redir_pc_d = {bus.mepc_i[31:2], 2'b00};
                end else if (take) begin
                    cause_d = code_sel;
                    if (bus.pipe_ready_i) begin
                        epc_d    = bus.pc_resume_i;
                        mcause_d = {1'b1, 26'd0, code_sel};
                        state_d  = S_SAVE;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
            end

            S_DRAIN: begin
                // Cause was fixed at decision time; sources dropping now do
                // not cancel the trap.
                if (bus.pipe_ready_i) begin
                    epc_d    = bus.pc_resume_i;
                    mcause_d = {1'b1, 26'd0, cause_q};
                    state_d  = S_SAVE;
                end
            end

            S_SAVE: begin
                redir_pc_d = trap_target;
                state_d    = S_REDIR;
            end

            S_REDIR: begin
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                state_d = S_IDLE;
            end

            S_MRET: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cause_q    <= 5'd0;
            epc_q      <= 32'd0;
            mcause_q   <= 32'd0;
            redir_pc_q <= 32'd0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            mcause_q   <= mcause_d;
            redir_pc_q <= redir_pc_d;
            cnt_q      <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: strobes decode directly from the state, data outputs are
    // registered so they hold their last value between sequences.
    // -------------------------------------------------------------------------
    assign bus.stall_o        = (state_q == S_DRAIN) || (state_q == S_SAVE);
    assign bus.trap_we_o      = (state_q == S_SAVE);
    assign bus.mstatus_trap_o = (state_q == S_SAVE);
    assign bus.redirect_o     = (state_q == S_REDIR) || (state_q == S_MRET);
    assign bus.flush_o        = (state_q == S_REDIR) || (state_q == S_MRET);
    assign bus.mstatus_mret_o = (state_q == S_MRET);
    assign bus.busy_o         = (state_q != S_IDLE);

    assign bus.mepc_wdata_o   = {epc_q[31:2], 2'b00};
    assign bus.mcause_wdata_o = mcause_q;
    assign bus.redirect_pc_o  = redir_pc_q;
    assign bus.trap_count_o   = cnt_q;

    // The software/timer levels are live inputs; hold the view at zero while
    // reset is asserted so every output reads 0 during reset.
    assign bus.mip_o = rst ? 32'd0 : mip_live;

    // Bits that are architecturally present on the inputs but not consumed.
    logic unused_bits;
`ifdef TRAP_VECTORED_EN
    assign unused_bits = ^{bus.mie_i[31:12], bus.mie_i[10:8], bus.mie_i[6:4],
                           bus.mie_i[2:0], bus.mepc_i[1:0], epc_q[1:0]};
`else
    assign unused_bits = ^{bus.mie_i[31:12], bus.mie_i[10:8], bus.mie_i[6:4],
                           bus.mie_i[2:0], bus.mepc_i[1:0], epc_q[1:0],
                           bus.mtvec_i[1:0]};
`endif

endmodule

// File: tb/tb_trap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_trap_ctrl
//
// Drives trap_ctrl through directed and randomized trap/mret trials. Expected
// values come from a transaction-level model: the trial's outcome (no trap,
// mret, or trap with a given cause/epc/target) is worked out from the pending
// and enable rules first, then the expected per-cycle strobes are checked.
// -----------------------------------------------------------------------------
module tb_trap_ctrl;

    localparam int SYNC  = 2;
    localparam int CNT_W = 16;

    logic clk;
    logic rst;

    int checks;
    int failures;
    int model_cnt;
    int trial_no;

    trap_ctrl_if #(.CNT_W(CNT_W)) bus ();

    trap_ctrl #(
        .INTR_SYNC (SYNC),
        .CNT_W     (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Trap entry address derived from the mtvec rules.
    function automatic logic [31:0] exp_target(input logic [31:0] mtvec, input logic [4:0] code);
        logic [31:0] base;
        base = {mtvec[31:2], 2'b00};
`ifdef TRAP_VECTORED_EN
        if (mtvec[1:0] == 2'b01) return base + 32'(code) * 32'd4;
`endif
        return base;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_stall"},  32'(bus.stall_o),        32'd0);
        chk({tag, "_flush"},  32'(bus.flush_o),        32'd0);
        chk({tag, "_redir"},  32'(bus.redirect_o),     32'd0);
        chk({tag, "_rpc"},    bus.redirect_pc_o,       32'd0);
        chk({tag, "_we"},     32'(bus.trap_we_o),      32'd0);
        chk({tag, "_mepc"},   bus.mepc_wdata_o,        32'd0);
        chk({tag, "_mcause"}, bus.mcause_wdata_o,      32'd0);
        chk({tag, "_mstrap"}, 32'(bus.mstatus_trap_o), 32'd0);
        chk({tag, "_msret"},  32'(bus.mstatus_mret_o), 32'd0);
        chk({tag, "_mip"},    bus.mip_o,               32'd0);
        chk({tag, "_busy"},   32'(bus.busy_o),         32'd0);
        chk({tag, "_cnt"},    32'(bus.trap_count_o),   32'd0);
    endtask

    // One trial: settle the interrupt levels with MIE=0, then open the gate
    // for one decision edge and follow whatever sequence the rules predict.
    task automatic run_trial(input logic ext, input logic sw, input logic tmr,
                             input logic [31:0] mie, input logic mie_bit,
                             input logic [31:0] mtvec, input logic [31:0] mepc,
                             input logic mret, input int drain);
        logic [31:0] exp_mip;
        logic [31:0] pend;
        logic        take;
        logic [4:0]  code;
        logic [31:0] epc_exp;
        string       kind;

        bus.mstatus_mie_i = 1'b0;
        bus.is_mret_i     = 1'b0;
        bus.pipe_ready_i  = 1'b1;
        bus.intr_ext_i    = ext;
        bus.intr_sw_i     = sw;
        bus.intr_tmr_i    = tmr;
        bus.mie_i         = mie;
        bus.mtvec_i       = mtvec;
        bus.mepc_i        = mepc;
        repeat (SYNC + 1) step();

        exp_mip = (32'(ext) << 11) | (32'(tmr) << 7) | (32'(sw) << 3);
        chk("mip", bus.mip_o, exp_mip);
        chk("idle_busy", 32'(bus.busy_o), 32'd0);

        pend = exp_mip & mie;
        take = mie_bit && (pend[11] || pend[3] || pend[7]);
        code = pend[11] ? 5'd11 : (pend[3] ? 5'd3 : 5'd7);

        bus.mstatus_mie_i = mie_bit;
        bus.is_mret_i     = mret;
        bus.pipe_ready_i  = (drain == 0);
        bus.pc_resume_i   = $urandom;
        epc_exp           = bus.pc_resume_i;
        step();
        // Trap entry clears MIE in the CSR file; mret would restore it, but
        // the bench keeps it closed so each trial ends cleanly in IDLE.
        bus.mstatus_mie_i = 1'b0;
        bus.is_mret_i     = 1'b0;

        if (mret) begin
            kind = "mret";
            chk("mret_strobe", 32'(bus.mstatus_mret_o), 32'd1);
            chk("mret_redir",  32'(bus.redirect_o),     32'd1);
            chk("mret_flush",  32'(bus.flush_o),        32'd1);
            chk("mret_pc",     bus.redirect_pc_o,       {mepc[31:2], 2'b00});
            chk("mret_we",     32'(bus.trap_we_o),      32'd0);
            chk("mret_stall",  32'(bus.stall_o),        32'd0);
            step();
            chk("mret_done_busy",  32'(bus.busy_o),     32'd0);
            chk("mret_done_redir", 32'(bus.redirect_o), 32'd0);
        end else if (take) begin
            kind = "trap";
            for (int k = 0; k < drain; k++) begin
                chk("drain_stall", 32'(bus.stall_o),    32'd1);
                chk("drain_we",    32'(bus.trap_we_o),  32'd0);
                chk("drain_redir", 32'(bus.redirect_o), 32'd0);
                // Sources may drop and mret may appear; neither may matter.
                bus.intr_sw_i    = 1'($urandom);
                bus.intr_tmr_i   = 1'($urandom);
                bus.is_mret_i    = 1'($urandom);
                bus.pc_resume_i  = $urandom;
                epc_exp          = bus.pc_resume_i;
                bus.pipe_ready_i = (k == drain - 1);
                step();
            end
            chk("save_we",     32'(bus.trap_we_o),      32'd1);
            chk("save_mstrap", 32'(bus.mstatus_trap_o), 32'd1);
            chk("save_stall",  32'(bus.stall_o),        32'd1);
            chk("save_redir",  32'(bus.redirect_o),     32'd0);
            chk("save_mepc",   bus.mepc_wdata_o,        {epc_exp[31:2], 2'b00});
            chk("save_mcause", bus.mcause_wdata_o,      {1'b1, 26'd0, code});
            bus.is_mret_i = 1'($urandom);
            step();
            chk("redir_redir", 32'(bus.redirect_o),     32'd1);
            chk("redir_flush", 32'(bus.flush_o),        32'd1);
            chk("redir_pc",    bus.redirect_pc_o,       exp_target(mtvec, code));
            chk("redir_we",    32'(bus.trap_we_o),      32'd0);
            chk("redir_stall", 32'(bus.stall_o),        32'd0);
            chk("redir_msret", 32'(bus.mstatus_mret_o), 32'd0);
            bus.is_mret_i = 1'b0;
            if (model_cnt < (1 << CNT_W) - 1) model_cnt++;
            step();
            chk("post_busy",  32'(bus.busy_o),       32'd0);
            chk("post_redir", 32'(bus.redirect_o),   32'd0);
            chk("post_cnt",   32'(bus.trap_count_o), 32'(model_cnt));
        end else begin
            kind = "none";
            chk("gate_busy", 32'(bus.busy_o),    32'd0);
            chk("gate_we",   32'(bus.trap_we_o), 32'd0);
            step();
            chk("gate_busy2", 32'(bus.busy_o),       32'd0);
            chk("gate_stall", 32'(bus.stall_o),      32'd0);
            chk("gate_cnt",   32'(bus.trap_count_o), 32'(model_cnt));
        end
        bus.pipe_ready_i = 1'b1;
        trial_no++;
        $display("trial %0d: %s ext=%0d sw=%0d tmr=%0d mie=%03h MIE=%0d mtvec=%08h drain=%0d code=%0d",
                 trial_no, kind, ext, sw, tmr, mie[11:0], mie_bit, mtvec, drain, code);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        model_cnt = 0;
        trial_no  = 0;

        rst               = 1'b1;
        bus.intr_ext_i    = 1'b0;
        bus.intr_sw_i     = 1'b0;
        bus.intr_tmr_i    = 1'b0;
        bus.mstatus_mie_i = 1'b0;
        bus.mie_i         = 32'd0;
        bus.mtvec_i       = 32'd0;
        bus.mepc_i        = 32'd0;
        bus.is_mret_i     = 1'b0;
        bus.pipe_ready_i  = 1'b0;
        bus.pc_resume_i   = 32'd0;

        #2;
        check_all_zero("reset");
        step();
        step();
        rst = 1'b0;

        // Directed cases from the plan.
        run_trial(1'b0, 1'b0, 1'b1, 32'h080, 1'b1, 32'h100, 32'h0,  1'b0, 0); // timer, direct
        run_trial(1'b1, 1'b1, 1'b1, 32'h888, 1'b1, 32'h201, 32'h0,  1'b0, 0); // priority (+vector)
        run_trial(1'b0, 1'b1, 1'b0, 32'h008, 1'b1, 32'h400, 32'h0,  1'b0, 3); // drain 3 cycles
        run_trial(1'b0, 1'b0, 1'b1, 32'h080, 1'b1, 32'h100, 32'h80, 1'b1, 0); // mret beats take
        run_trial(1'b0, 1'b0, 1'b1, 32'h080, 1'b0, 32'h100, 32'h0,  1'b0, 0); // MIE=0 gate
        run_trial(1'b0, 1'b0, 1'b1, 32'h000, 1'b1, 32'h100, 32'h0,  1'b0, 0); // mie[7]=0 gate
        run_trial(1'b1, 1'b0, 1'b1, 32'h880, 1'b1, 32'h301, 32'h0,  1'b0, 1); // ext over timer

        // Reset while in DRAIN.
        bus.intr_tmr_i    = 1'b1;
        bus.mie_i         = 32'h080;
        bus.mstatus_mie_i = 1'b1;
        bus.pipe_ready_i  = 1'b0;
        step();
        chk("rstdrain_stall", 32'(bus.stall_o), 32'd1);
        rst = 1'b1;
        #2;
        check_all_zero("rst_in_drain");
        bus.mstatus_mie_i = 1'b0;
        step();
        rst       = 1'b0;
        model_cnt = 0;
        run_trial(1'b0, 1'b0, 1'b1, 32'h080, 1'b1, 32'h100, 32'h0, 1'b0, 2);

        // Randomized trials.
        for (int t = 0; t < 60; t++) begin
            logic [31:0] mie_r;
            mie_r     = 32'($urandom);
            mie_r[11] = ($urandom_range(0, 3) != 0);
            mie_r[7]  = ($urandom_range(0, 3) != 0);
            mie_r[3]  = ($urandom_range(0, 3) != 0);
            run_trial(1'($urandom), 1'($urandom), 1'($urandom), mie_r,
                      ($urandom_range(0, 4) != 0), 32'($urandom), 32'($urandom),
                      ($urandom_range(0, 6) == 0), int'($urandom_range(0, 4)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Trap sequencer for the 3-stage RISC-V core. It sits between the interrupt sources, the pipeline control and the machine CSR file.
- Arbitrates pending machine interrupts (external, software, timer) and decides when a trap is taken.
- On trap entry, it drains the pipeline, writes mepc/mcause/mstatus through a dedicated CSR trap-write port, then flushes and redirects fetch to the mtvec target.
- On mret, it restores mstatus and redirects fetch to mepc.

Parameters:
- INTR_SYNC, 2: number of synchronizer flops on intr_ext_i. Legal range 0..3; 0 means used directly.
- CNT_W, 16: width of the saturating trap counter trap_count_o.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- intr_ext_i  in  1  machine external interrupt, level, asynchronous to clk
- intr_sw_i  in  1  machine software interrupt, level, synchronous
- intr_tmr_i  in  1  machine timer interrupt, level, synchronous
- mstatus_mie_i  in  1  mstatus.MIE from CSR file
- mie_i  in  32  mie CSR; bits 11/3/7 used
- mtvec_i  in  32  mtvec CSR
- mepc_i  in  32  mepc CSR
- is_mret_i  in  1  mret in execute stage, valid this cycle
- pipe_ready_i  in  1  pipeline may be interrupted (no memory access or CSR write in flight)
- pc_resume_i  in  32  PC of oldest uncommitted instruction
- stall_o  out  1  freeze fetch/decode
- flush_o  out  1  kill all in-flight instructions
- redirect_o  out  1  load redirect_pc_o into PC
- redirect_pc_o  out  32  fetch target
- trap_we_o  out  1  one-cycle CSR trap write strobe
- mepc_wdata_o  out  32  value for mepc
- mcause_wdata_o  out  32  value for mcause
- mstatus_trap_o  out  1  CSR file sets MPIE=MIE, then MIE=0
- mstatus_mret_o  out  1  CSR file sets MIE=MPIE, then MPIE=1
- mip_o  out  32  live mip view: bit11=ext_sync, bit3=sw, bit7=tmr, others 0
- busy_o  out  1  FSM not in IDLE
- trap_count_o  out  CNT_W  traps taken, saturating

Behaviour:
- Reset: state IDLE; all outputs 0; synchronizer flops cleared; captured epc and cause cleared.
- Pending sets:
  - pend = mip_o & mie_i.
  - take = mstatus_mie_i & (pend[11] | pend[3] | pend[7]).
- Fixed priority: MEI (cause 11) > MSI (cause 3) > MTI (cause 7).
- mcause_wdata_o = {1'b1, 26'b0, code[4:0]}.
- FSM states: IDLE, DRAIN, SAVE, REDIR, MRET.
- IDLE:
  - If is_mret_i, go to MRET. mret has priority over take in the same cycle; the interrupt is re-evaluated after return.
  - Else if take, latch the cause code:
    - pipe_ready_i=1: latch epc=pc_resume_i and go to SAVE.
    - pipe_ready_i=0: go to DRAIN with stall_o=1.
- DRAIN:
  - stall_o=1.
  - When pipe_ready_i=1, latch epc=pc_resume_i and go to SAVE.
  - The cause is latched at decision time. A source deasserting while in DRAIN does not cancel the trap.
- SAVE (1 cycle):
  - trap_we_o=1, mstatus_trap_o=1, stall_o=1.
  - mepc_wdata_o = {epc[31:2], 2'b00}; mcause_wdata_o = latched cause.
  - Next state REDIR.
- REDIR (1 cycle):
  - redirect_o=1, flush_o=1.
  - redirect_pc_o = vector target.
  - trap_count_o increments, saturating at all-ones.
  - Next state IDLE.
- MRET (1 cycle):
  - mstatus_mret_o=1, redirect_o=1, flush_o=1.
  - redirect_pc_o = {mepc_i[31:2], 2'b00}.
  - Next state IDLE.
- Strobe outputs are 0 outside their states. mepc_wdata_o, mcause_wdata_o and redirect_pc_o hold their last value.
- Trap latency with pipe_ready_i=1: decision in cycle N, trap_we_o in N+1, redirect_o in N+2.
- Back-to-back: no new trap can be taken in the cycle after REDIR. mstatus.MIE is 0, so take is 0 until mret or software re-enables it.
- is_mret_i asserted in DRAIN/SAVE/REDIR is ignored; the flush kills that instruction.
- Reset mid-sequence: immediate return to IDLE, no partial strobes.
- intr_ext_i passes through INTR_SYNC flops before use, both in mip_o and in arbitration.

Optional Feature:
- Macro TRAP_VECTORED_EN.
- Defined:
  - mtvec_i[1:0]=01 selects vectored mode: target = {mtvec_i[31:2], 2'b00} + (code << 2), 32-bit wrap.
  - mode 00 selects direct mode.
  - modes 1x are treated as direct.
- Undefined: mtvec_i[1:0] is ignored; target is always {mtvec_i[31:2], 2'b00}.

Test Plan:
- Timer trap, direct: mtvec=0x100, mie[7]=1, MIE=1, pc_resume=0x2C, intr_tmr 0->1 -> trap_we pulse with mepc=0x2C, mcause=0x80000007, mstatus_trap=1; next cycle redirect_pc=0x100 with flush; trap_count=1.
- Priority plus vectored (TRAP_VECTORED_EN): ext, sw and tmr all pending and enabled, mtvec=0x201 -> mcause=0x8000000B, redirect_pc=0x22C.
- Drain: take with pipe_ready=0 for 3 cycles -> stall_o high 3 cycles, no trap_we; SAVE one cycle after pipe_ready rises; mepc equals pc_resume at that cycle.
- mret vs interrupt: is_mret and take in the same cycle, mepc=0x80 -> mstatus_mret pulse, redirect_pc=0x80, no trap_we.
- Gating: pending timer with MIE=0 or mie[7]=0 -> no trap; mip_o[7]=1; busy_o stays 0.
- Reset in DRAIN: rst pulse -> all outputs 0, IDLE; after release with the interrupt still pending, the trap sequence restarts normally.
